// File: rtl/alu_exec_stage.sv
// Registered execute stage around a 32-bit combinational ALU (AND/OR/ADD/SUB/SLT).
// Define ALU_EXEC_SKID_BUF_EN to add a one-entry skid buffer and a registered in_ready.
package alu_exec_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
endpackage

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);
    import alu_exec_pkg::*;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // NOTE: every output gets a default before the case, so no latches are inferred.
    always_comb begin
        sub      = (ALUop == OP_SUB) || (ALUop == OP_SLT);
        b_eff    = sub ? ~B : B;
        sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        Result   = '0;
        CarryOut = 1'b0;
        case (ALUop)
            OP_AND: Result = A & B;
            OP_OR:  Result = A | B;
            OP_ADD: begin
                Result   = sum[WIDTH-1:0];
                CarryOut = sum[WIDTH];
            end
            OP_SUB: begin
                Result   = sum[WIDTH-1:0];
                CarryOut = !sum[WIDTH];
            end
            // Signed less-than: sign of A-B corrected by overflow.
            OP_SLT: Result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ Overflow};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end
endmodule

module alu_exec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [2:0]            in_ALUop,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_overflow,
    output logic                  out_carryout,
    output logic                  out_illegal,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [7:0]            ovf_cnt
);
    import alu_exec_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  overflow;
        logic                  carry;
        logic                  illegal;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  alu_carry;

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .A        (in_A),
        .B        (in_B),
        .ALUop    (in_ALUop),
        .Result   (alu_result),
        .Zero     (alu_zero),
        .Overflow (alu_overflow),
        .CarryOut (alu_carry)
    );

    entry_t     new_entry;
    entry_t     out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic       illegal_op, addsub_op;
    logic       handoff, out_free, accept;
`ifdef ALU_EXEC_SKID_BUF_EN
    entry_t     skid_q, skid_d;
    logic       skid_valid_q, skid_valid_d;
`endif

    always_comb begin
        illegal_op = !(in_ALUop inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT});
        addsub_op  = (in_ALUop == OP_ADD) || (in_ALUop == OP_SUB);

        new_entry.result   = illegal_op ? '0 : alu_result;
        new_entry.zero     = illegal_op | alu_zero;
        new_entry.overflow = addsub_op & alu_overflow;
        new_entry.carry    = !illegal_op & alu_carry;
        new_entry.illegal  = illegal_op;
        new_entry.tag      = in_tag;
    end

    always_comb begin
        handoff  = out_valid_q & out_ready;
        out_free = !out_valid_q | out_ready;
`ifdef ALU_EXEC_SKID_BUF_EN
        in_ready = !skid_valid_q & !flush & !rst;
`else
        in_ready = out_free & !flush & !rst;
`endif
        accept      = in_valid & in_ready;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef ALU_EXEC_SKID_BUF_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        // A held skid entry drains first; in_ready is low while it is occupied.
        if (out_free && skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (!out_free && accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end else
`endif
        if (out_free) begin
            out_valid_d = accept;
            if (accept) out_d = new_entry;
        end

        ovf_cnt_d = ovf_cnt_q;
        if (handoff && !flush && out_q.overflow && ovf_cnt_q != 8'hFF)
            ovf_cnt_d = ovf_cnt_q + 8'd1;

        if (flush) begin
            out_valid_d = 1'b0;
`ifdef ALU_EXEC_SKID_BUF_EN
            skid_valid_d = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

`ifdef ALU_EXEC_SKID_BUF_EN
    // NOTE: only the skid valid bit is reset; its payload is never observed while invalid.
    always_ff @(posedge clk) begin
        if (rst) skid_valid_q <= 1'b0;
        else     skid_valid_q <= skid_valid_d;
        skid_q <= skid_d;
    end
`endif

    assign out_valid    = out_valid_q;
    assign out_result   = out_q.result;
    assign out_zero     = out_q.zero;
    assign out_overflow = out_q.overflow;
    assign out_carryout = out_q.carry;
    assign out_illegal  = out_q.illegal;
    assign out_tag      = out_q.tag;
    assign ovf_cnt      = ovf_cnt_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus random traffic against a queue model.
module tb_alu_exec_stage;
    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, SLT = 3'b111, AND_ = 3'b000, OR_ = 3'b001;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -MAXS - 1;
`ifdef ALU_EXEC_SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_A, in_B;
    logic [2:0]  in_ALUop;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_zero, out_overflow, out_carryout, out_illegal;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [7:0]  ovf_cnt;

    alu_exec_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
        .out_carryout(out_carryout), .out_illegal(out_illegal), .out_tag(out_tag),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        carry;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    exp_t        mq[$];
    int unsigned mcnt = 0;
    bit          started = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [4:0] tag);
        exp_t   e;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        e.tag = tag;
        case (op)
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            ADD: begin
                r = sa + sb;
                e.res = a + b;
                e.ovf = (r > MAXS) || (r < MINS);
                e.carry = ((64'(a) + 64'(b)) >> 32) != 0;
            end
            SUB: begin
                r = sa - sb;
                e.res = a - b;
                e.ovf = (r > MAXS) || (r < MINS);
                e.carry = a < b;
            end
            SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic bit model_ready();
        bit r;
        if (CAP == 2) r = mq.size() < 2;
        else          r = (mq.size() == 0) || out_ready;
        return r && !flush && !rst;
    endfunction

    // Reference model advances on each rising edge using the sampled inputs.
    always @(posedge clk) begin
        bit acc, ho;
        acc = in_valid && model_ready();
        ho  = (mq.size() != 0) && out_ready;
        if (rst) begin
            mq.delete();
            mcnt = 0;
            started = 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (ho) begin
                if (mq[0].ovf && mcnt < 255) mcnt++;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(model(in_A, in_B, in_ALUop, in_tag));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_in_ready", in_ready, model_ready());
            check("m_out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("m_result", out_result, mq[0].res);
                check("m_zero", out_zero, mq[0].zero);
                check("m_ovf", out_overflow, mq[0].ovf);
                check("m_carry", out_carryout, mq[0].carry);
                check("m_illegal", out_illegal, mq[0].ill);
                check("m_tag", out_tag, mq[0].tag);
            end
            check("m_ovf_cnt", ovf_cnt, mcnt);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [4:0] tag);
        bit rdy, done;
        in_A = a; in_B = b; in_ALUop = op; in_tag = tag; in_valid = 1'b1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            done = rdy;
        end
        #1 in_valid = 1'b0;
        if (!done) check("issue_timeout", 0, 1);
    endtask

    task automatic expect_out(input string n, input logic [31:0] res, input logic z,
                              input logic ov, input logic c, input logic il, input logic [4:0] tag);
        check({n, "_valid"}, out_valid, 1);
        check({n, "_result"}, out_result, res);
        check({n, "_zero"}, out_zero, z);
        check({n, "_ovf"}, out_overflow, ov);
        check({n, "_carry"}, out_carryout, c);
        check({n, "_illegal"}, out_illegal, il);
        check({n, "_tag"}, out_tag, tag);
    endtask

    task automatic expect_reset(input string n);
        check({n, "_in_ready"}, in_ready, 1);
        check({n, "_valid"}, out_valid, 0);
        check({n, "_result"}, out_result, 0);
        check({n, "_flags"}, {out_zero, out_overflow, out_carryout, out_illegal}, 0);
        check({n, "_tag"}, out_tag, 0);
        check({n, "_ovf_cnt"}, ovf_cnt, 0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         accepted, cur, n_out;
        bit         rdy;
        logic [4:0] got_tags [3];
        int         got_cyc  [3];

        rst = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_A = 0; in_B = 0; in_ALUop = 0; in_tag = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        expect_reset("post_rst");

        // Directed arithmetic cases
        sync();
        issue(32'h7FFFFFFF, 32'h1, ADD, 5'd3);
        @(negedge clk);
        expect_out("add_ovf", 32'h80000000, 0, 1, 0, 0, 5'd3);
        sync();
        @(negedge clk);
        check("add_ovf_cnt", ovf_cnt, 1);
        sync();
        issue(32'h0, 32'h1, SUB, 5'd4);
        @(negedge clk);
        expect_out("sub_borrow", 32'hFFFFFFFF, 0, 0, 1, 0, 5'd4);
        sync();
        issue(32'hFFFFFFFF, 32'h1, SLT, 5'd5);
        @(negedge clk);
        expect_out("slt_neg", 32'h1, 0, 0, 0, 0, 5'd5);
        sync();
        issue(32'hF0F0F0F0, 32'h0F0F0F0F, AND_, 5'd6);
        @(negedge clk);
        expect_out("and_zero", 32'h0, 1, 0, 0, 0, 5'd6);
        sync();
        issue(32'd5, 32'd7, 3'b011, 5'd8);
        @(negedge clk);
        expect_out("illegal", 32'h0, 1, 0, 0, 1, 5'd8);

        // Backpressure: four stalled cycles offering tags 1..3, then drain
        sync();
        accepted = 0; cur = 1; n_out = 0;
        for (int i = 0; i < 20 && n_out < 3; i++) begin
            out_ready = (i >= 4);
            in_valid  = (cur <= 3);
            in_A = $urandom; in_B = $urandom; in_ALUop = OR_; in_tag = 5'(cur);
            @(negedge clk);
            rdy = in_ready;
            if (i == 3) check("bp_in_ready_low", in_ready, 0);
            if (out_valid && out_ready) begin
                got_tags[n_out] = out_tag;
                got_cyc[n_out]  = i;
                n_out++;
            end
            @(posedge clk);
            #1;
            if (rdy && in_valid) begin
                if (i < 4) accepted++;
                cur++;
            end
        end
        in_valid = 0;
        check("bp_accepted", accepted, CAP);
        check("bp_out_count", n_out, 3);
        if (n_out == 3) begin
            check("bp_tag0", got_tags[0], 1);
            check("bp_tag1", got_tags[1], 2);
            check("bp_tag2", got_tags[2], 3);
            check("bp_span", got_cyc[2] - got_cyc[0], 2);
        end

        // Flush with the stage full; the overflowing head must not be counted
        sync();
        out_ready = 0;
        issue(32'h7FFFFFFF, 32'h1, ADD, 5'd10);
        if (CAP == 2) issue(32'h7FFFFFFF, 32'h1, ADD, 5'd11);
        flush = 1; out_ready = 1; in_valid = 1;
        in_A = 32'h1; in_B = 32'h1; in_ALUop = ADD; in_tag = 5'd12;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_ovf_cnt", ovf_cnt, 1);
        sync();
        @(negedge clk);
        check("flush_no_revive", out_valid, 0);

        // Reset mid-stream with a held entry
        sync();
        out_ready = 0;
        issue(32'h7FFFFFFF, 32'h1, ADD, 5'd7);
        rst = 1; in_valid = 1; in_tag = 5'd9;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        expect_reset("midrst");

        // Random traffic
        sync();
        for (int i = 0; i < 2000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 49) == 0;
            in_A      = rand_opnd();
            in_B      = rand_opnd();
            in_ALUop  = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            sync();
        end
        flush = 0; in_valid = 0; out_ready = 1;

        // Counter saturation
        rst = 1;
        sync();
        sync();
        rst = 0;
        for (int k = 0; k < 300; k++) issue(32'h7FFFFFFF, 32'h1, ADD, 5'(k));
        repeat (3) sync();
        @(negedge clk);
        check("sat_ovf_cnt", ovf_cnt, 255);
        check("sat_model_cnt", mcnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapped around the 32-bit combinational `alu` (AND/OR/ADD/SUB/SLT). It accepts one operation per cycle from decode over a valid/ready handshake and evaluates it through an instance of `alu`. It registers the result, flags and destination tag toward write-back, and counts overflowing results. It adds backpressure, flush and an optional skid buffer, so the combinational ALU can sit in a pipelined datapath.

## Interface
- `DATA_WIDTH`, 32: operand/result width; must equal the `alu` width.
- `TAG_WIDTH`, 5: destination register tag width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous kill of all in-flight entries.
- `in_valid` input 1: upstream operation valid.
- `in_ready` output 1: stage can accept.
- `in_A`, `in_B` input DATA_WIDTH: operands.
- `in_ALUop` input 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; the other three codes are illegal.
- `in_tag` input TAG_WIDTH: destination tag, passed through unchanged.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts.
- `out_result` output DATA_WIDTH: ALU result.
- `out_zero`, `out_overflow`, `out_carryout` output 1 each: flags.
- `out_illegal` output 1: the op was an illegal code.
- `out_tag` output TAG_WIDTH: tag.
- `ovf_cnt` output 8: saturating count of overflowing results handed off.

## Operation
- Accept happens when `in_valid & in_ready`.
- The operands drive `alu` combinationally in the accept cycle. The result, flags, tag and illegal bit are captured at that clock edge.
- Flags:
  - `out_overflow` = ALU Overflow masked to 0 unless op is ADD/SUB.
  - `out_carryout` = ALU CarryOut: ADD carry-out, SUB borrow, else 0.
  - `out_zero` = ALU Zero.
- Illegal op: captured with result 0, zero 1, overflow 0, carry 0, `out_illegal` 1. It is never dropped.
- Handoff happens when `out_valid & out_ready`. On handoff, if `out_overflow` = 1, `ovf_cnt` increments and saturates at 255.
- Order is strictly FIFO. There is no reordering and no duplication.
- `flush` = 1:
  - `out_valid` and any buffered entry are cleared at the edge.
  - `in_ready` is 0 that cycle, so nothing is accepted.
  - Handoff in the flush cycle does not count toward `ovf_cnt`.
- `rst` takes priority over `flush`.
- Reset values:
  - `out_valid`, `out_result`, flags, `out_illegal`, `out_tag`, `ovf_cnt` all reset to 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after.
- Reset mid-operation discards all entries. `ovf_cnt` clears.

## Timing
- Latency: accept at edge N gives `out_valid` = 1 after edge N.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Output register: holds its value stable while `out_valid & !out_ready`.
- Output register: loads a new entry when it is empty, or when it is full and handing off, in the same cycle. Either the skid entry (priority) or the incoming op loads.
- Simultaneous handoff and accept in the same cycle: both happen, with no bubble.
- `ovf_cnt` updates one edge after handoff.

## Configuration
- `ALU_EXEC_SKID_BUF_EN` defined:
  - Adds one skid entry holding a registered ALU result, flags, tag and illegal bit.
  - `in_ready` is a registered signal = !skid_valid & !flush. It has no combinational path from `out_ready`.
  - An op accepted while the output is stalled goes to the skid entry.
  - When the output is freed, the skid entry moves into the output the next edge.
  - Capacity is 2 entries.
- `ALU_EXEC_SKID_BUF_EN` undefined:
  - There is no skid entry. Capacity is 1.
  - `in_ready` = (!out_valid | out_ready) & !flush & !rst, combinationally.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, tag 3, `out_ready` = 1 → next cycle result 0x80000000, overflow 1, carry 0, zero 0, tag 3. `ovf_cnt` = 1 after handoff.
- SUB 0x00000000 − 0x00000001 → result 0xFFFFFFFF, carry 1, overflow 0. Then SLT 0xFFFFFFFF, 0x00000001 → result 1, overflow 0. Then AND 0xF0F0F0F0, 0x0F0F0F0F → result 0, zero 1.
- Backpressure: `out_ready` = 0 for 4 cycles while offering ops tagged 1, 2, 3.
  - Skid build: tags 1 and 2 accepted, `in_ready` drops to 0.
  - Non-skid build: only tag 1 accepted.
  - After `out_ready` rises: tags emerge 1, 2, 3 in order, one per cycle, with no loss.
- Illegal op 3'b011, A = 5, B = 7 → result 0, zero 1, `out_illegal` 1, overflow 0.
- Flush with 2 entries held: `out_valid` = 0 next cycle, `in_ready` = 0 during the flush cycle, `ovf_cnt` unchanged. Then reset mid-stream → all outputs 0, `in_ready` = 1 the cycle after `rst` falls.
- Issue 300 overflowing ADDs → `ovf_cnt` saturates at 255.
